// File: rtl/spi_slave_reg_ctrl.sv
// Byte-level register access controller sitting behind an SPI slave.
// First byte of a frame is {rd, addr[6:0]}; writes follow, reads return data on MISO.
module spi_slave_reg_ctrl #(
  parameter logic [7:0] STATUS_BYTE = 8'hA5,
  parameter int         AUTO_INC    = 1
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_SPI_CS_n,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic       o_TX_DV,
  output logic [7:0] o_TX_Byte,
  output logic [6:0] o_Reg_Addr,
  output logic       o_Reg_Wr_En,
  output logic [7:0] o_Reg_Wr_Data,
  output logic       o_Reg_Rd_En,
  input  logic [7:0] i_Reg_Rd_Data,
  output logic       o_Busy,
  output logic       o_Overrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_WR_DATA, S_RD_FETCH, S_RD_LOAD, S_RD_WAIT
  } t_State;

  t_State     r_State;
  t_State     w_NextState;
  logic       r_CsMeta, r_CsSync, r_CsPrev;
  logic       w_CsFall, w_CsRise;
  logic [6:0] r_Addr;
  logic [6:0] w_RdAddr;
  logic       w_WrStb, w_RdStb, w_TxLoad, w_AddrLoad, w_Inc, w_SetOvr, w_Start, w_GoIdle;
  logic       r_TxDv, r_WrEn, r_RdEn, r_Busy, r_Overrun, r_PendStatus;
  logic [7:0] r_TxByte, r_WrData;
  logic [6:0] r_RegAddr;

  // CS_n is a raw pad: two-flop synchroniser plus a third flop for edge detection.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_CsMeta <= 1'b1;
      r_CsSync <= 1'b1;
      r_CsPrev <= 1'b1;
    end else begin
      r_CsMeta <= i_SPI_CS_n;
      r_CsSync <= r_CsMeta;
      r_CsPrev <= r_CsSync;
    end
  end

  assign w_CsFall = r_CsPrev & ~r_CsSync;
  assign w_CsRise = ~r_CsPrev & r_CsSync;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) r_State <= S_IDLE;
    else       r_State <= w_NextState;
  end

  always_comb begin
    w_NextState = r_State;
    w_WrStb     = 1'b0;
    w_RdStb     = 1'b0;
    w_RdAddr    = r_Addr;
    w_TxLoad    = 1'b0;
    w_AddrLoad  = 1'b0;
    w_Inc       = 1'b0;
    w_SetOvr    = 1'b0;
    w_Start     = 1'b0;
    // A frame end pre-empts everything, so a byte racing the CS rise is dropped.
    if (r_State != S_IDLE && w_CsRise) begin
      w_NextState = S_IDLE;
    end else begin
      case (r_State)
        S_IDLE: if (w_CsFall) begin
          w_NextState = S_CMD;
          w_Start     = 1'b1;
        end
        S_CMD: if (i_RX_DV) begin
          w_AddrLoad = 1'b1;
          if (i_RX_Byte[7]) begin
            w_NextState = S_RD_FETCH;
            w_RdStb     = 1'b1;
            w_RdAddr    = i_RX_Byte[6:0];
          end else begin
            w_NextState = S_WR_DATA;
          end
        end
        S_WR_DATA: if (i_RX_DV) begin
          w_WrStb = 1'b1;
          w_Inc   = (AUTO_INC != 0);
        end
        S_RD_FETCH: begin
          w_NextState = S_RD_LOAD;
          w_SetOvr    = i_RX_DV;
        end
        S_RD_LOAD: begin
          w_NextState = S_RD_WAIT;
          w_TxLoad    = 1'b1;
          w_Inc       = (AUTO_INC != 0);
          w_SetOvr    = i_RX_DV;
        end
        S_RD_WAIT: if (i_RX_DV) begin
          w_NextState = S_RD_FETCH;
          w_RdStb     = 1'b1;
        end
        default: w_NextState = S_IDLE;
      endcase
    end
  end

  assign w_GoIdle = (r_State != S_IDLE) && (w_NextState == S_IDLE);

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_Addr       <= 7'd0;
      r_RegAddr    <= 7'd0;
      r_WrEn       <= 1'b0;
      r_WrData     <= 8'h00;
      r_RdEn       <= 1'b0;
      r_TxDv       <= 1'b0;
      r_TxByte     <= 8'h00;
      r_Busy       <= 1'b0;
      r_Overrun    <= 1'b0;
      r_PendStatus <= 1'b1;
    end else begin
      r_WrEn <= w_WrStb;
      r_RdEn <= w_RdStb;
      r_TxDv <= 1'b0;
      if (w_AddrLoad)  r_Addr <= i_RX_Byte[6:0];
      else if (w_Inc)  r_Addr <= r_Addr + 7'd1;
      if (w_WrStb) begin
        r_RegAddr <= r_Addr;
        r_WrData  <= i_RX_Byte;
      end else if (w_RdStb) begin
        r_RegAddr <= w_RdAddr;
      end
      if (w_Start)       r_Overrun <= 1'b0;
      else if (w_SetOvr) r_Overrun <= 1'b1;
      if (w_Start)       r_Busy <= 1'b1;
      else if (w_GoIdle) r_Busy <= 1'b0;
      // Status preload fires on the first IDLE cycle after reset or a frame end.
      if (w_GoIdle) begin
        r_PendStatus <= 1'b1;
      end else if (r_PendStatus) begin
        r_PendStatus <= 1'b0;
        r_TxDv       <= 1'b1;
        r_TxByte     <= STATUS_BYTE;
      end else if (w_TxLoad) begin
        r_TxDv   <= 1'b1;
        r_TxByte <= i_Reg_Rd_Data;
      end
    end
  end

  assign o_TX_DV       = r_TxDv;
  assign o_TX_Byte     = r_TxByte;
  assign o_Reg_Addr    = r_RegAddr;
  assign o_Reg_Wr_En   = r_WrEn;
  assign o_Reg_Wr_Data = r_WrData;
  assign o_Reg_Rd_En   = r_RdEn;
  assign o_Busy        = r_Busy;
  assign o_Overrun     = r_Overrun;

endmodule

// File: tb/tb_spi_slave_reg_ctrl.sv
// Directed bench for spi_slave_reg_ctrl: one auto-increment instance and one fixed-address
// instance share all inputs; a register-file responder answers read strobes of the first.
module tb_spi_slave_reg_ctrl;

  logic       i_Clk = 1'b0;
  logic       i_Rst;
  logic       i_SPI_CS_n;
  logic       i_RX_DV;
  logic [7:0] i_RX_Byte;
  logic [7:0] i_Reg_Rd_Data;

  logic       o_TX_DV, fx_TX_DV;
  logic [7:0] o_TX_Byte, fx_TX_Byte;
  logic [6:0] o_Reg_Addr, fx_Reg_Addr;
  logic       o_Reg_Wr_En, fx_Reg_Wr_En;
  logic [7:0] o_Reg_Wr_Data, fx_Reg_Wr_Data;
  logic       o_Reg_Rd_En, fx_Reg_Rd_En;
  logic       o_Busy, fx_Busy;
  logic       o_Overrun, fx_Overrun;

  logic [7:0] mem [0:127];
  int nTests = 0;
  int nFail  = 0;

  always #5 i_Clk = ~i_Clk;

  spi_slave_reg_ctrl #(.STATUS_BYTE(8'hA5), .AUTO_INC(1)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_SPI_CS_n(i_SPI_CS_n),
    .i_RX_DV(i_RX_DV), .i_RX_Byte(i_RX_Byte),
    .o_TX_DV(o_TX_DV), .o_TX_Byte(o_TX_Byte),
    .o_Reg_Addr(o_Reg_Addr), .o_Reg_Wr_En(o_Reg_Wr_En), .o_Reg_Wr_Data(o_Reg_Wr_Data),
    .o_Reg_Rd_En(o_Reg_Rd_En), .i_Reg_Rd_Data(i_Reg_Rd_Data),
    .o_Busy(o_Busy), .o_Overrun(o_Overrun)
  );

  spi_slave_reg_ctrl #(.STATUS_BYTE(8'hA5), .AUTO_INC(0)) dutFixed (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_SPI_CS_n(i_SPI_CS_n),
    .i_RX_DV(i_RX_DV), .i_RX_Byte(i_RX_Byte),
    .o_TX_DV(fx_TX_DV), .o_TX_Byte(fx_TX_Byte),
    .o_Reg_Addr(fx_Reg_Addr), .o_Reg_Wr_En(fx_Reg_Wr_En), .o_Reg_Wr_Data(fx_Reg_Wr_Data),
    .o_Reg_Rd_En(fx_Reg_Rd_En), .i_Reg_Rd_Data(i_Reg_Rd_Data),
    .o_Busy(fx_Busy), .o_Overrun(fx_Overrun)
  );

  // Register file: data appears the cycle after a read strobe seen on the first instance.
  initial begin : rdResponder
    logic       pend;
    logic [6:0] addr;
    i_Reg_Rd_Data = 8'h00;
    forever begin
      @(negedge i_Clk);
      pend = o_Reg_Rd_En;
      addr = o_Reg_Addr;
      @(posedge i_Clk);
      #1;
      if (pend) i_Reg_Rd_Data = mem[addr];
    end
  end

  initial begin : watchdog
    #50000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation timeout");
  end

  task automatic tick;
    @(posedge i_Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    i_RX_Byte = b;
    i_RX_DV   = 1'b1;
    tick();
    i_RX_DV   = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // CS falls; two sync flops plus edge detect put the frame in CMD three cycles later.
  task automatic startFrame(input string tag);
    i_SPI_CS_n = 1'b0;
    repeat (3) tick();
    checkOutput({tag, "_busy_set"}, o_Busy, 1);
  endtask

  task automatic endFrame(input string tag);
    i_SPI_CS_n = 1'b1;
    repeat (3) tick();
    checkOutput({tag, "_busy_clr"}, o_Busy, 0);
    tick();
    checkOutput({tag, "_status_dv"}, o_TX_DV, 1);
    checkOutput({tag, "_status_byte"}, o_TX_Byte, 8'hA5);
    tick();
  endtask

  initial begin : stimulus
    i_Rst      = 1'b1;
    i_SPI_CS_n = 1'b1;
    i_RX_DV    = 1'b0;
    i_RX_Byte  = 8'h00;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[7'h7E] = 8'hAB;
    mem[7'h7F] = 8'hCD;
    mem[7'h00] = 8'hEF;
    mem[7'h05] = 8'h5A;

    repeat (3) tick();
    checkOutput("rst_tx_dv", o_TX_DV, 0);
    checkOutput("rst_tx_byte", o_TX_Byte, 8'h00);
    checkOutput("rst_addr", o_Reg_Addr, 7'h00);
    checkOutput("rst_wr_en", o_Reg_Wr_En, 0);
    checkOutput("rst_wr_data", o_Reg_Wr_Data, 8'h00);
    checkOutput("rst_rd_en", o_Reg_Rd_En, 0);
    checkOutput("rst_busy", o_Busy, 0);
    checkOutput("rst_overrun", o_Overrun, 0);

    i_Rst = 1'b0;
    tick();
    checkOutput("rel_status_dv", o_TX_DV, 1);
    checkOutput("rel_status_byte", o_TX_Byte, 8'hA5);
    tick();
    checkOutput("rel_status_one_cycle", o_TX_DV, 0);

    applyStimulus(8'h12);
    checkOutput("idle_ignore_wr", o_Reg_Wr_En, 0);
    checkOutput("idle_ignore_busy", o_Busy, 0);
    tick();

    // Write burst starting at 0x10
    startFrame("wr");
    applyStimulus(8'h10);
    checkOutput("wr_cmd_no_strobe", o_Reg_Wr_En, 0);
    tick();
    applyStimulus(8'h11);
    checkOutput("wr0_en", o_Reg_Wr_En, 1);
    checkOutput("wr0_addr", o_Reg_Addr, 7'h10);
    checkOutput("wr0_data", o_Reg_Wr_Data, 8'h11);
    tick();
    checkOutput("wr0_one_cycle", o_Reg_Wr_En, 0);
    checkOutput("wr0_addr_hold", o_Reg_Addr, 7'h10);
    applyStimulus(8'h22);
    checkOutput("wr1_en", o_Reg_Wr_En, 1);
    checkOutput("wr1_addr", o_Reg_Addr, 7'h11);
    checkOutput("wr1_data", o_Reg_Wr_Data, 8'h22);
    tick();
    applyStimulus(8'h33);
    checkOutput("wr2_en", o_Reg_Wr_En, 1);
    checkOutput("wr2_addr", o_Reg_Addr, 7'h12);
    checkOutput("wr2_data", o_Reg_Wr_Data, 8'h33);
    checkOutput("wr2_rd_en_low", o_Reg_Rd_En, 0);
    checkOutput("fx_wr2_addr", fx_Reg_Addr, 7'h10);
    tick();
    endFrame("wr");

    // Read burst from 0x7E across the address wrap
    startFrame("rd");
    applyStimulus(8'hFE);
    checkOutput("rd0_en", o_Reg_Rd_En, 1);
    checkOutput("rd0_addr", o_Reg_Addr, 7'h7E);
    checkOutput("rd0_wr_en_low", o_Reg_Wr_En, 0);
    tick();
    checkOutput("rd0_one_cycle", o_Reg_Rd_En, 0);
    tick();
    checkOutput("rd0_tx_dv", o_TX_DV, 1);
    checkOutput("rd0_tx_byte", o_TX_Byte, 8'hAB);
    tick();
    checkOutput("rd0_tx_one_cycle", o_TX_DV, 0);
    checkOutput("rd0_tx_hold", o_TX_Byte, 8'hAB);
    applyStimulus(8'h00);
    checkOutput("rd1_addr", o_Reg_Addr, 7'h7F);
    repeat (2) tick();
    checkOutput("rd1_tx_dv", o_TX_DV, 1);
    checkOutput("rd1_tx_byte", o_TX_Byte, 8'hCD);
    tick();
    applyStimulus(8'h00);
    checkOutput("rd2_en", o_Reg_Rd_En, 1);
    checkOutput("rd2_addr_wrap", o_Reg_Addr, 7'h00);
    repeat (2) tick();
    checkOutput("rd2_tx_dv", o_TX_DV, 1);
    checkOutput("rd2_tx_byte", o_TX_Byte, 8'hEF);
    tick();
    applyStimulus(8'h00);
    repeat (3) tick();
    endFrame("rd");

    // Overrun: a byte lands while the read is still being fetched
    startFrame("ovr");
    applyStimulus(8'h85);
    checkOutput("ovr_rd_en", o_Reg_Rd_En, 1);
    checkOutput("ovr_rd_addr", o_Reg_Addr, 7'h05);
    applyStimulus(8'h77);
    checkOutput("ovr_flag_set", o_Overrun, 1);
    tick();
    checkOutput("ovr_tx_dv", o_TX_DV, 1);
    checkOutput("ovr_tx_byte", o_TX_Byte, 8'h5A);
    tick();
    endFrame("ovr");
    checkOutput("ovr_sticky", o_Overrun, 1);
    startFrame("ovr2");
    checkOutput("ovr_cleared", o_Overrun, 0);
    endFrame("ovr2");

    // Abort: CS rise is detected while the read is in RD_LOAD
    startFrame("abt");
    i_RX_Byte  = 8'h81;
    i_RX_DV    = 1'b1;
    i_SPI_CS_n = 1'b1;
    tick();
    i_RX_DV = 1'b0;
    checkOutput("abt_rd_en", o_Reg_Rd_En, 1);
    repeat (2) tick();
    checkOutput("abt_no_tx", o_TX_DV, 0);
    checkOutput("abt_busy_clr", o_Busy, 0);
    tick();
    checkOutput("abt_status_dv", o_TX_DV, 1);
    checkOutput("abt_status_byte", o_TX_Byte, 8'hA5);
    tick();

    // Reset in the middle of a write frame
    startFrame("rmw");
    applyStimulus(8'h20);
    i_Rst      = 1'b1;
    i_SPI_CS_n = 1'b1;
    #1;
    checkOutput("rmw_busy", o_Busy, 0);
    checkOutput("rmw_addr", o_Reg_Addr, 7'h00);
    checkOutput("rmw_tx_byte", o_TX_Byte, 8'h00);
    i_RX_Byte = 8'h21;
    i_RX_DV   = 1'b1;
    tick();
    i_RX_DV = 1'b0;
    checkOutput("rmw_no_wr", o_Reg_Wr_En, 0);
    tick();
    i_Rst = 1'b0;
    tick();
    checkOutput("rmw_status_dv", o_TX_DV, 1);
    checkOutput("rmw_status_byte", o_TX_Byte, 8'hA5);
    repeat (2) tick();
    startFrame("post");
    applyStimulus(8'h40);
    tick();
    applyStimulus(8'h01);
    checkOutput("post_wr0_en", o_Reg_Wr_En, 1);
    checkOutput("post_wr0_addr", o_Reg_Addr, 7'h40);
    checkOutput("post_wr0_data", o_Reg_Wr_Data, 8'h01);
    tick();
    applyStimulus(8'h02);
    checkOutput("post_wr1_addr", o_Reg_Addr, 7'h41);
    tick();
    endFrame("post");

    // Fixed-address instance against the auto-increment instance
    startFrame("fix");
    applyStimulus(8'h05);
    tick();
    applyStimulus(8'h01);
    checkOutput("fix_wr0_en", fx_Reg_Wr_En, 1);
    checkOutput("fix_wr0_addr", fx_Reg_Addr, 7'h05);
    checkOutput("fix_wr0_data", fx_Reg_Wr_Data, 8'h01);
    tick();
    applyStimulus(8'h02);
    checkOutput("fix_wr1_en", fx_Reg_Wr_En, 1);
    checkOutput("fix_wr1_addr", fx_Reg_Addr, 7'h05);
    checkOutput("fix_wr1_data", fx_Reg_Wr_Data, 8'h02);
    checkOutput("inc_wr1_addr", o_Reg_Addr, 7'h06);
    tick();
    endFrame("fix");

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
